multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV32 core. Fetches each instruction over a req/ready handshake, latches the opcode and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same datapath controls the single-cycle decoder produced (ALUOp, ALUSrc, RegWrite), plus PC, IR and memory controls.
- Also provides a retired-instruction counter and a memory-timeout error.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret_o.
- TIMEOUT, 16, max cycles to wait for any memory ready; range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  leave IDLE and begin fetching (level, sampled in IDLE only).
- instr_i  in  32  instruction word from imem, valid when imem_ready_i=1.
- imem_ready_i  in  1  imem read data valid.
- dmem_ready_i  in  1  dmem access complete.
- zero_i  in  1  ALU zero flag, valid in EXEC.
- imem_req_o  out  1  imem read request.
- dmem_req_o  out  1  dmem access request.
- dmem_we_o  out  1  dmem write (store) when dmem_req_o=1.
- ir_write_o  out  1  load IR from instr_i.
- pc_write_o  out  1  PC <= PC+4.
- pc_branch_o  out  1  PC <= branch target.
- ALUOp  out  2  00 add/I-type, 01 R-type funct decode, 10 subtract (branch compare).
- ALUSrc  out  1  1 = immediate operand, 0 = rs2.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  1 = writeback from dmem data.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky memory-timeout / illegal-opcode flag.
- instret_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_i=0, async): state=IDLE, opcode register=0, wait counter=0, instret_o=0, err_o=0. All other outputs are 0.
- Outputs are Moore, decoded from the state register and the latched opcode. No output depends combinationally on a *_ready_i input except ir_write_o and pc_write_o.
- IDLE:
  - start_i=1 -> FETCH.
  - Else stay in IDLE.
- FETCH:
  - imem_req_o=1.
  - If imem_ready_i=1: ir_write_o=1 and pc_write_o=1 in that same cycle, latch instr_i[6:0] as opcode, go to DECODE.
- DECODE (1 cycle):
  - Opcode 0010011, 0110011, 0000011, 0100011 or 1100011 -> EXEC.
  - Any other opcode -> set err_o, go to FETCH. Not counted in instret_o.
- EXEC (1 cycle):
  - I-type 0010011: ALUOp=00, ALUSrc=1, next WB.
  - R-type 0110011: ALUOp=01, ALUSrc=0, next WB.
  - Load 0000011 / store 0100011: ALUOp=00, ALUSrc=1, next MEM.
  - Branch 1100011: ALUOp=10, ALUSrc=0, pc_branch_o=zero_i, instret++, next FETCH.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 for store only.
  - On dmem_ready_i: load -> WB; store -> instret++, FETCH.
  - Request is held stable (req, we) until ready.
- WB (1 cycle):
  - RegWrite=1; MemtoReg=1 for load, else 0.
  - ALUOp/ALUSrc hold their EXEC values.
  - instret++, next FETCH.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle ready is low.
  - When it reaches TIMEOUT with ready still low: set err_o, drop the request, go to IDLE.
  - Ready arriving in the same cycle as the limit wins; no error.
- err_o is sticky and clears only on reset. The block continues operating after err_o is set.
- instret_o wraps modulo 2^CNT_W.
- start_i is ignored outside IDLE.
- Reset mid-transaction aborts immediately. Requests drop asynchronously with rst_i.

Test Plan:
- Reset then start_i=1; imem returns 0x00500093 (addi) with ready on the 1st cycle -> states FETCH, DECODE, EXEC (ALUOp=00, ALUSrc=1), WB (RegWrite=1); instret_o=1 after 4 cycles.
- R-type 0x002081B3 with imem_ready_i delayed 3 cycles -> imem_req_o held 4 cycles; ir_write_o/pc_write_o pulse exactly once; EXEC ALUOp=01, ALUSrc=0.
- Load 0x0000A103 then store 0x0020A023 with dmem_ready_i after 2 cycles -> load: MEM then WB with MemtoReg=1. Store: dmem_we_o=1, no WB, RegWrite never 1. instret_o=2.
- Branch 0x00208463 with zero_i=1, then with zero_i=0 -> pc_branch_o=1 in EXEC for the first case only; no RegWrite; each retires in 3 cycles.
- TIMEOUT=4, imem_ready_i held 0 -> imem_req_o drops after 4 cycles, err_o=1, state IDLE. Illegal opcode 0x0000007F -> err_o=1, instret_o unchanged, next FETCH.
- rst_i pulsed low mid-MEM -> dmem_req_o=0 asynchronously, instret_o=0, err_o=0, state IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake and datapath-control bundle between the multi-cycle sequencer and the core/memories.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start_i;
    logic [31:0]      instr_i;
    logic             imem_ready_i;
    logic             dmem_ready_i;
    logic             zero_i;
    logic             imem_req_o;
    logic             dmem_req_o;
    logic             dmem_we_o;
    logic             ir_write_o;
    logic             pc_write_o;
    logic             pc_branch_o;
    logic [1:0]       ALUOp;
    logic             ALUSrc;
    logic             RegWrite;
    logic             MemtoReg;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] instret_o;

    // Sequencer side: it issues the memory requests and drives the datapath controls
    modport master (
        input  start_i, instr_i, imem_ready_i, dmem_ready_i, zero_i,
        output imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, pc_branch_o,
               ALUOp, ALUSrc, RegWrite, MemtoReg, busy_o, err_o, instret_o
    );

    // Environment side: memories, datapath and the start source
    modport slave (
        output start_i, instr_i, imem_ready_i, dmem_ready_i, zero_i,
        input  imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, pc_branch_o,
               ALUOp, ALUSrc, RegWrite, MemtoReg, busy_o, err_o, instret_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout and retire counter.
module multicycle_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              err_q, err_d;

    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_branch;
    logic [1:0] alu_op;
    logic       alu_src, reg_write, mem_to_reg;

    logic       is_imm, is_reg, is_load, is_store, is_branch, op_legal;
    logic [1:0] alu_op_dec;
    logic       alu_src_dec;
    logic       unused_instr;

    // Only the opcode field of the fetched word matters to the sequencer
    assign unused_instr = ^bus.instr_i[31:7];

    // Opcode class and ALU control decode from the latched opcode
    always_comb begin
        is_imm      = (opcode_q == OP_IMM);
        is_reg      = (opcode_q == OP_REG);
        is_load     = (opcode_q == OP_LOAD);
        is_store    = (opcode_q == OP_STORE);
        is_branch   = (opcode_q == OP_BRANCH);
        op_legal    = is_imm | is_reg | is_load | is_store | is_branch;
        alu_op_dec  = is_reg ? 2'b01 : (is_branch ? 2'b10 : 2'b00);
        alu_src_dec = ~(is_reg | is_branch);
    end

    // State, opcode, wait counter, retire counter and sticky error registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    // Next-state and Moore output decode; only ir/pc write follow imem ready directly
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_d     = wait_q;
        instret_d  = instret_q;
        err_d      = err_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_branch  = 1'b0;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    opcode_d = bus.instr_i[6:0];
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op  = alu_op_dec;
                alu_src = alu_src_dec;
                if (is_branch) begin
                    pc_branch = bus.zero_i;
                    instret_d = instret_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_op   = alu_op_dec;
                alu_src  = alu_src_dec;
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (bus.dmem_ready_i) begin
                    if (is_store) begin
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                alu_op     = alu_op_dec;
                alu_src    = alu_src_dec;
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                instret_d  = instret_q + CNT_W'(1);
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Every state change is an entry into a fresh wait window
        if (state_d != state_q) wait_d = '0;
    end

    // Drive the interface
    assign bus.imem_req_o  = imem_req;
    assign bus.dmem_req_o  = dmem_req;
    assign bus.dmem_we_o   = dmem_we;
    assign bus.ir_write_o  = ir_write;
    assign bus.pc_write_o  = pc_write;
    assign bus.pc_branch_o = pc_branch;
    assign bus.ALUOp       = alu_op;
    assign bus.ALUSrc      = alu_src;
    assign bus.RegWrite    = reg_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.err_o       = err_q;
    assign bus.instret_o   = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table-driven instruction stream with a scoreboard, plus timeout/reset sequences.
module tb_multicycle_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        int          idly;
        int          ddly;
        logic        zero;
        int          len;
        int          req_len;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        rw;
        logic        m2r;
        logic        we;
        logic        br;
        int          ret;
        logic        err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];
    vec_t sb_q [$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // Observation state owned by the monitor
    bit          col = 1'b0;
    int          cyc, req_run, ob_req, ir_cnt, pc_cnt;
    logic [1:0]  ob_aluop;
    logic        ob_src, ob_br, ob_rw, ob_m2r, ob_we;
    logic [31:0] ret0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Compare one completed instruction against the oldest expected record
    task automatic finalize();
        vec_t e;
        chk("sb_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk("len",       64'(cyc),    64'(e.len));
        chk("req_len",   64'(ob_req), 64'(e.req_len));
        chk("ir_pulses", 64'(ir_cnt), 64'd1);
        chk("pc_pulses", 64'(pc_cnt), 64'd1);
        chk("aluop",     64'(ob_aluop), 64'(e.aluop));
        chk("alusrc",    64'(ob_src), 64'(e.alusrc));
        chk("regwrite",  64'(ob_rw),  64'(e.rw));
        chk("memtoreg",  64'(ob_m2r), 64'(e.m2r));
        chk("dmem_we",   64'(ob_we),  64'(e.we));
        chk("pc_branch", 64'(ob_br),  64'(e.br));
        chk("instret_d", 64'(bus.instret_o - ret0), 64'(e.ret));
        chk("err",       64'(bus.err_o), 64'(e.err));
    endtask

    // Monitor: sample away from the active edge and build per-instruction observations
    always @(negedge clk_i) begin
        if (mon_en && rst_i) begin
            if (col) begin
                cyc++;
                if (bus.imem_req_o || !bus.busy_o) begin
                    finalize();
                    col = 1'b0;
                end else begin
                    if (cyc == 2) begin
                        ob_aluop = bus.ALUOp;
                        ob_src   = bus.ALUSrc;
                        ob_br    = bus.pc_branch_o;
                    end
                    ob_rw  = ob_rw  | bus.RegWrite;
                    ob_m2r = ob_m2r | bus.MemtoReg;
                    ob_we  = ob_we  | (bus.dmem_req_o & bus.dmem_we_o);
                    ir_cnt += int'(bus.ir_write_o);
                    pc_cnt += int'(bus.pc_write_o);
                end
            end
            if (bus.imem_req_o) req_run++;
            if (bus.ir_write_o) begin
                col      = 1'b1;
                cyc      = 0;
                ob_req   = req_run;
                req_run  = 0;
                ir_cnt   = 1;
                pc_cnt   = int'(bus.pc_write_o);
                ob_aluop = 2'b00;
                ob_src   = 1'b0;
                ob_br    = 1'b0;
                ob_rw    = 1'b0;
                ob_m2r   = 1'b0;
                ob_we    = 1'b0;
                ret0     = bus.instret_o;
            end else if (!bus.imem_req_o) begin
                req_run = 0;
            end
        end else begin
            col     = 1'b0;
            req_run = 0;
        end
    end

    // Serve one instruction fetch after waiting for the request
    task automatic fetch(input logic [31:0] instr, input int idly);
        int n = 0;
        while (!bus.imem_req_o && n < 20) begin tick(); n++; end
        chk("fetch_req_seen", 64'(bus.imem_req_o), 64'd1);
        repeat (idly) tick();
        bus.instr_i      = instr;
        bus.imem_ready_i = 1'b1;
        tick();
        bus.imem_ready_i = 1'b0;
    endtask

    // Drive one table record: fetch, serve any dmem access, run to the next fetch
    task automatic run_instr(input vec_t v);
        int n = 0;
        bus.zero_i = v.zero;
        while (!bus.imem_req_o && n < 50) begin tick(); n++; end
        if (!bus.imem_req_o) begin
            chk("imem_req_wait", 64'(bus.imem_req_o), 64'd1);
            return;
        end
        sb_q.push_back(v);
        fetch(v.instr, v.idly);
        n = 0;
        while (!bus.imem_req_o && bus.busy_o && n < 50) begin
            if (bus.dmem_req_o) begin
                repeat (v.ddly) tick();
                bus.dmem_ready_i = 1'b1;
                tick();
                bus.dmem_ready_i = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        if (n >= 50) chk("instr_done_wait", 64'(n), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          instr         idly ddly z  len req aluop  src   rw    m2r   we    br  ret err
        vecs[0] = '{32'h00500093, 0, 0, 1'b0, 4, 1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[1] = '{32'h002081B3, 3, 0, 1'b0, 4, 4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[2] = '{32'h0000A103, 0, 2, 1'b0, 7, 1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vecs[3] = '{32'h0020A023, 0, 2, 1'b0, 6, 1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vecs[4] = '{32'h00208463, 0, 0, 1'b1, 3, 1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[5] = '{32'h00208463, 1, 0, 1'b0, 3, 2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[6] = '{32'h00100113, 3, 0, 1'b0, 4, 4, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[7] = '{32'h0000A103, 0, 3, 1'b0, 8, 1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vecs[8] = '{32'h0000007F, 0, 0, 1'b0, 2, 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1};

        bus.start_i      = 1'b0;
        bus.instr_i      = '0;
        bus.imem_ready_i = 1'b0;
        bus.dmem_ready_i = 1'b0;
        bus.zero_i       = 1'b0;

        // Reset state
        #12;
        chk("rst_busy",     64'(bus.busy_o),     64'd0);
        chk("rst_imem_req", 64'(bus.imem_req_o), 64'd0);
        chk("rst_dmem_req", 64'(bus.dmem_req_o), 64'd0);
        chk("rst_regwrite", 64'(bus.RegWrite),   64'd0);
        chk("rst_err",      64'(bus.err_o),      64'd0);
        chk("rst_instret",  64'(bus.instret_o),  64'd0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("idle_no_start", 64'(bus.busy_o), 64'd0);

        // Instruction stream through the scoreboard
        mon_en      = 1'b1;
        bus.start_i = 1'b1;
        for (int i = 0; i < NVEC; i++) run_instr(vecs[i]);
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin tick(); n++; end
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("instret_total", 64'(bus.instret_o), 64'd8);
        mon_en      = 1'b0;
        bus.start_i = 1'b0;

        // imem never ready: request for exactly TIMEOUT cycles, then error and IDLE
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("rst2_err", 64'(bus.err_o), 64'd0);
        tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 0;
        while (bus.imem_req_o && n < 20) begin n++; tick(); end
        chk("to_req_cycles", 64'(n),              64'd4);
        chk("to_err",        64'(bus.err_o),      64'd1);
        chk("to_idle",       64'(bus.busy_o),     64'd0);
        chk("to_req_drop",   64'(bus.imem_req_o), 64'd0);
        chk("to_instret",    64'(bus.instret_o),  64'd0);

        // Retire one, then reset asynchronously while a load waits in MEM
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        fetch(32'h00500093, 0);
        fetch(32'h0000A103, 0);
        chk("mid_instret", 64'(bus.instret_o), 64'd1);
        n = 0;
        while (!bus.dmem_req_o && n < 20) begin tick(); n++; end
        chk("mid_dmem_req", 64'(bus.dmem_req_o), 64'd1);
        chk("mid_err",      64'(bus.err_o),      64'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_dmem_req", 64'(bus.dmem_req_o), 64'd0);
        chk("arst_busy",     64'(bus.busy_o),     64'd0);
        chk("arst_instret",  64'(bus.instret_o),  64'd0);
        chk("arst_err",      64'(bus.err_o),      64'd0);
        tick();
        rst_i = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
